// File: rtl/loop_prof_pkg.sv
// Shared types for the loop transaction profiler: FSM state encoding and the
// record carried through the output FIFO.
package loop_prof_pkg;

  // Record fields are stored at this width; narrower profilers zero-extend.
  localparam int unsigned REC_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_FLUSHED = 2'd2
  } loop_prof_state_e;

  typedef struct packed {
    logic [REC_CNT_W-1:0] latency;
    logic [REC_CNT_W-1:0] iters;
    logic [REC_CNT_W-1:0] issued;
    logic [REC_CNT_W-1:0] stalls;
    logic                 partial;
  } loop_prof_rec_t;

endpackage

// File: rtl/prof_rec_fifo.sv
// Synchronous record FIFO with a registered head; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module prof_rec_fifo
  import loop_prof_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  loop_prof_rec_t push_data_i,
  input  logic           ready_i,
  output logic           valid_o,
  output logic           full_o,
  output loop_prof_rec_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic           valid_q, valid_d, full_q, full_d;
  logic           pop, accept;
  loop_prof_rec_t head_q, head_d;
  loop_prof_rec_t mem_q [DEPTH];

  always_comb begin
    pop    = valid_q && ready_i;
    accept = push_i && (!full_q || pop);
    wr_d   = accept ? wr_q + PW'(1) : wr_q;
    rd_d   = pop ? rd_q + PW'(1) : rd_q;
    valid_d = (wr_d != rd_d);
    full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
    // Bypass the incoming record when it becomes the new head.
    if (accept && (wr_q == rd_d)) begin
      head_d = push_data_i;
    end else begin
      head_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      head_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      full_q  <= full_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_q[AW-1:0]] <= push_data_i;
    end
  end

  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign head_o  = head_q;

endmodule

// File: rtl/loop_txn_profiler.sv
// Per-transaction loop profiler: counts latency, iterations and stalls for each
// start..done transaction and queues one record per transaction.
module loop_txn_profiler
  import loop_prof_pkg::*;
#(
  parameter int unsigned CNT_W = 32,  // must not exceed REC_CNT_W
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             loop_start,
  input  logic             loop_done,
  input  logic             iter_start_fire,
  input  logic             iter_end_fire,
  input  logic             stall,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_iters,
  output logic [CNT_W-1:0] rec_issued,
  output logic [CNT_W-1:0] rec_stalls,
  output logic             rec_partial,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy_err
);

  loop_prof_state_e state_q, state_d;
  logic [CNT_W-1:0] lat_q, lat_d, iters_q, iters_d, issued_q, issued_d;
  logic [CNT_W-1:0] stalls_q, stalls_d, drop_q, drop_d;
  logic             busy_q, busy_d;
  logic             push, fifo_full, fifo_valid, drop;
  loop_prof_rec_t   push_rec, head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Next-state, counter update and record push decision.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    iters_d  = iters_q;
    issued_d = issued_q;
    stalls_d = stalls_q;
    busy_d   = busy_q;
    push     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (finish) begin
          state_d = ST_FLUSHED;
        end else if (loop_start) begin
          lat_d    = CNT_W'(1);
          iters_d  = CNT_W'(iter_end_fire);
          issued_d = CNT_W'(iter_start_fire);
          stalls_d = CNT_W'(stall);
          if (loop_done) begin
            push = 1'b1;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        lat_d    = sat_inc(lat_q, 1'b1);
        iters_d  = sat_inc(iters_q, iter_end_fire);
        issued_d = sat_inc(issued_q, iter_start_fire);
        stalls_d = sat_inc(stalls_q, stall);
        if (loop_start) begin
          busy_d = 1'b1;
        end
        if (loop_done || finish) begin
          push    = 1'b1;
          state_d = finish ? ST_FLUSHED : ST_IDLE;
        end
      end
      default: begin
      end
    endcase

    push_rec.latency = REC_CNT_W'(lat_d);
    push_rec.iters   = REC_CNT_W'(iters_d);
    push_rec.issued  = REC_CNT_W'(issued_d);
    push_rec.stalls  = REC_CNT_W'(stalls_d);
    push_rec.partial = !loop_done;

    drop   = push && fifo_full && !(fifo_valid && rec_ready);
    drop_d = sat_inc(drop_q, drop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      lat_q    <= '0;
      iters_q  <= '0;
      issued_q <= '0;
      stalls_q <= '0;
      busy_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      iters_q  <= iters_d;
      issued_q <= issued_d;
      stalls_q <= stalls_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  prof_rec_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clock),
    .rst_n      (reset),
    .push_i     (push),
    .push_data_i(push_rec),
    .ready_i    (rec_ready),
    .valid_o    (fifo_valid),
    .full_o     (fifo_full),
    .head_o     (head)
  );

  assign rec_valid   = fifo_valid;
  assign rec_latency = CNT_W'(head.latency);
  assign rec_iters   = CNT_W'(head.iters);
  assign rec_issued  = CNT_W'(head.issued);
  assign rec_stalls  = CNT_W'(head.stalls);
  assign rec_partial = head.partial;
  assign drop_count  = drop_q;
  assign busy_err    = busy_q;

endmodule
